// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, FSM state type and default timeout for the
// two-requester ALU arbiter.
package alu_pkg;

  localparam int unsigned OP_W                = 4;
  localparam int unsigned OPC_W               = 3;
  localparam int unsigned RES_W               = 8;
  localparam int unsigned N_REQ               = 2;
  localparam int unsigned ALU_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter.
// Ports:
//   req             - request vector, bit N = requester N
//   last_grant      - index of the requester granted on the previous handshake
//   update          - a handshake happens this cycle; advance the pointer
//   grant           - one-hot grant (all zero when nobody requests)
//   next_last_grant - next value for the caller's last_grant register
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       update,
  output logic [1:0] grant,
  output logic       next_last_grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Both requesting: whoever was not served last goes first.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    next_last_grant = last_grant;
    if (update && (grant != 2'b00)) begin
      next_last_grant = grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// A request is accepted in IDLE, launched with a one-cycle alu_start, and the
// result (or a timeout error) is held on rsp_* until the owner accepts it.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   req_valid/req_ready        - per-requester request handshake
//   req_op1/req_op2/req_opcode - packed per-requester operands and opcode
//   rsp_valid/rsp_ready        - per-requester response handshake
//   rsp_data/rsp_err           - shared result and timeout flag
//   alu_op1/alu_op2/alu_opcode - operands/opcode to the shared ALU
//   alu_start                  - one-cycle ALU launch
//   alu_done/alu_result        - ALU completion strobe and result
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = ALU_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*OP_W-1:0]  req_op1,
  input  logic [N_REQ*OP_W-1:0]  req_op2,
  input  logic [N_REQ*OPC_W-1:0] req_opcode,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [RES_W-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic [OP_W-1:0]        alu_op1,
  output logic [OP_W-1:0]        alu_op2,
  output logic [OPC_W-1:0]       alu_opcode,
  output logic                   alu_start,
  input  logic                   alu_done,
  input  logic [RES_W-1:0]       alu_result
);

  // Wide enough to hold ALU_TIMEOUT itself.
  localparam int unsigned CntW = (ALU_TIMEOUT < 1) ? 1 : $clog2(ALU_TIMEOUT + 1);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  logic             r_owner;
  logic             r_last_grant;
  logic [OP_W-1:0]  r_op1;
  logic [OP_W-1:0]  r_op2;
  logic [OPC_W-1:0] r_opc;
  logic [CntW-1:0]  r_cnt;
  logic [RES_W-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic [1:0]       w_grant;
  logic             w_grant_idx;
  logic             w_next_last_grant;
  logic             w_hs;
  logic [CntW-1:0]  w_cnt_inc;
  logic             w_timeout;

  assign w_grant_idx = w_grant[1];
  assign w_hs        = (r_state == StIdle) && ((req_valid & w_grant) != 2'b00);
  assign w_cnt_inc   = r_cnt + 1'b1;
  // Fires on the WAIT cycle whose increment would reach ALU_TIMEOUT, giving
  // exactly ALU_TIMEOUT WAIT cycles before the abort.
  assign w_timeout   = (w_cnt_inc == CntW'(ALU_TIMEOUT));

  rr_arb2 u_rr_arb2 (
    .req             (req_valid),
    .last_grant      (r_last_grant),
    .update          (w_hs),
    .grant           (w_grant),
    .next_last_grant (w_next_last_grant)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_hs) w_state_next = StIssue;
      StIssue: w_state_next = StWait;
      StWait:  if (alu_done || w_timeout) w_state_next = StResp;
      StResp:  if (rsp_ready[r_owner]) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    alu_start = 1'b0;
    case (r_state)
      StIdle:  req_ready = req_valid & w_grant;
      StIssue: alu_start = 1'b1;
      StResp:  rsp_valid = r_owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign alu_op1    = r_op1;
  assign alu_op2    = r_op2;
  assign alu_opcode = r_opc;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;

  // Request latches, owner, round-robin pointer, timeout counter, response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_op1        <= '0;
      r_op2        <= '0;
      r_opc        <= '0;
      r_cnt        <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_last_grant <= w_next_last_grant;
      case (r_state)
        StIdle: begin
          if (w_hs) begin
            r_owner <= w_grant_idx;
            r_op1   <= w_grant_idx ? req_op1[OP_W +: OP_W]     : req_op1[0 +: OP_W];
            r_op2   <= w_grant_idx ? req_op2[OP_W +: OP_W]     : req_op2[0 +: OP_W];
            r_opc   <= w_grant_idx ? req_opcode[OPC_W +: OPC_W] : req_opcode[0 +: OPC_W];
          end
        end
        StIssue: r_cnt <= '0;
        StWait: begin
          // alu_done has priority over a same-cycle timeout.
          if (alu_done) begin
            r_rsp_data <= alu_result;
            r_rsp_err  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomized bench for alu_arbiter. The bench plays the ALU and
// both requesters; a transaction-level model predicts owner, wait count,
// response data and error flag.
module tb_alu_arbiter;

  localparam int TMO = 15;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_op1;
  logic [7:0] req_op2;
  logic [5:0] req_opcode;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] alu_op1;
  logic [3:0] alu_op2;
  logic [2:0] alu_opcode;
  logic       alu_start;
  logic       alu_done;
  logic [7:0] alu_result;

  int         n_vec;
  int         n_fail;
  logic       m_last;     // model: requester served on the last handshake
  logic [7:0] m_data;     // model: value rsp_data currently holds

  alu_arbiter #(.ALU_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_opcode (alu_opcode),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    logic [7:0] wa;
    logic [7:0] wb;
    wa = {4'h0, a};
    wb = {4'h0, b};
    case (op)
      3'd0:    return wa + wb;
      3'd1:    return wa - wb;
      3'd2:    return wa & wb;
      3'd3:    return wa | wb;
      3'd4:    return wa ^ wb;
      3'd5:    return wa * wb;
      default: return {a, b};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_last = 1'b1;
    m_data = 8'h00;
    tick();
  endtask

  // One full transaction starting from IDLE at posedge+1.
  // delay: WAIT cycle (1-based) in which alu_done is returned, 0 = never.
  // bp:    cycles of response back-pressure.
  task automatic run_txn(input logic [1:0] vmask, input logic [7:0] op1, input logic [7:0] op2,
                         input logic [5:0] opc, input int delay, input int bp);
    int         own;
    int         exp_waits;
    int         waits;
    logic [1:0] oh;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] o;
    logic       exp_done;
    logic [7:0] exp_data;
    logic       got;

    if (vmask == 2'b01)      own = 0;
    else if (vmask == 2'b10) own = 1;
    else                     own = m_last ? 0 : 1;
    oh = (own == 1) ? 2'b10 : 2'b01;
    a  = (own == 1) ? op1[7:4] : op1[3:0];
    b  = (own == 1) ? op2[7:4] : op2[3:0];
    o  = (own == 1) ? opc[5:3] : opc[2:0];
    exp_done  = (delay >= 1) && (delay <= TMO);
    exp_waits = exp_done ? delay : TMO;
    exp_data  = exp_done ? alu_fn(a, b, o) : 8'h00;

    req_valid  = vmask;
    req_op1    = op1;
    req_op2    = op2;
    req_opcode = opc;
    rsp_ready  = 2'b00;
    #1;
    check("req_ready_idle", 32'(req_ready), 32'(oh));
    @(posedge clk);
    #1;
    m_last = (own == 1);
    check("issue_start", 32'(alu_start), 32'd1);
    check("issue_op1", 32'(alu_op1), 32'(a));
    check("issue_op2", 32'(alu_op2), 32'(b));
    check("issue_opcode", 32'(alu_opcode), 32'(o));
    check("issue_req_ready", 32'(req_ready), 32'd0);
    tick();
    check("start_single_pulse", 32'(alu_start), 32'd0);

    waits = 0;
    got   = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      waits = k;
      if (k == delay) begin
        alu_done   = 1'b1;
        alu_result = alu_fn(a, b, o);
      end
      tick();
      alu_done   = 1'b0;
      alu_result = 8'($urandom);
      got = (rsp_valid != 2'b00);
    end
    check("wait_cycles", 32'(waits), 32'(exp_waits));

    for (int i = 0; i <= bp; i++) begin
      check("rsp_valid", 32'(rsp_valid), 32'(oh));
      check("rsp_data", 32'(rsp_data), 32'(exp_data));
      check("rsp_err", 32'(rsp_err), 32'(!exp_done));
      check("resp_req_ready", 32'(req_ready), 32'd0);
      check("resp_alu_ops", 32'({alu_op1, alu_op2, alu_opcode}), 32'({a, b, o}));
      if (i < bp) begin
        // Only the non-owner accepts, and a stray alu_done arrives.
        rsp_ready  = ~oh;
        alu_done   = 1'b1;
        alu_result = 8'($urandom);
        tick();
      end
    end
    alu_done  = 1'b0;
    rsp_ready = oh;
    tick();
    check("rsp_released", 32'(rsp_valid), 32'd0);
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    m_data    = exp_data;
  endtask

  initial begin
    n_vec      = 0;
    n_fail     = 0;
    m_last     = 1'b1;
    m_data     = 8'h00;
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_op1    = 8'h00;
    req_op2    = 8'h00;
    req_opcode = 6'h00;
    rsp_ready  = 2'b00;
    alu_done   = 1'b0;
    alu_result = 8'h00;

    // Reset state.
    #3;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_alu_start", 32'(alu_start), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_alu_latches", 32'({alu_op1, alu_op2, alu_opcode}), 32'h0);
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();

    // Single request, 3 + 5.
    run_txn(2'b01, 8'h03, 8'h05, 6'o00, 1, 0);
    check("single_data", 32'(rsp_data), 32'h08);

    // Contention from reset: owners 0, 1, 0.
    do_reset();
    run_txn(2'b11, 8'h21, 8'h43, 6'o12, 1, 0);
    check("contend_last_1", 32'(m_last), 32'd0);
    run_txn(2'b11, 8'h65, 8'h87, 6'o34, 3, 1);
    check("contend_last_2", 32'(m_last), 32'd1);
    run_txn(2'b11, 8'hA9, 8'hCB, 6'o56, 2, 0);
    check("contend_last_3", 32'(m_last), 32'd0);

    // Timeout, back-pressure, boundary.
    run_txn(2'b10, 8'h7C, 8'h3E, 6'o45, 0, 0);
    run_txn(2'b01, 8'h9D, 8'h2B, 6'o03, 2, 5);
    run_txn(2'b01, 8'h4F, 8'h61, 6'o01, TMO, 0);
    run_txn(2'b10, 8'h5A, 8'hC3, 6'o20, TMO + 1, 2);

    // Stray alu_done in IDLE.
    for (int i = 0; i < 3; i++) begin
      alu_done   = 1'b1;
      alu_result = 8'hAA;
      tick();
      check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
      check("stray_alu_start", 32'(alu_start), 32'd0);
      check("stray_rsp_data", 32'(rsp_data), 32'(m_data));
    end
    alu_done = 1'b0;

    // Reset while in WAIT drops the request.
    req_valid = 2'b10;
    req_op1   = 8'h12;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_alu_start", 32'(alu_start), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_alu_op1", 32'(alu_op1), 32'd0);
    tick();
    rst    = 1'b0;
    m_last = 1'b1;
    m_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      alu_done   = 1'b1;
      alu_result = 8'h5C;
      tick();
      check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("postrst_alu_start", 32'(alu_start), 32'd0);
    end
    alu_done = 1'b0;
    run_txn(2'b11, 8'h34, 8'h12, 6'o41, 1, 0);
    check("postrst_first_owner", 32'(m_last), 32'd0);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      run_txn(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 6'($urandom),
              int'($urandom_range(0, TMO + 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_TIMEOUT, default 15, is the maximum number of WAIT cycles before a request is aborted with an error.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester request valid; bit N belongs to requester N.
REQ-005 req_ready  out  2  per-requester request accept.
REQ-006 req_op1  in  8  operand 1, requester N at bits [4N+3:4N].
REQ-007 req_op2  in  8  operand 2, same packing as req_op1.
REQ-008 req_opcode  in  6  opcode, requester N at bits [3N+2:3N].
REQ-009 rsp_valid  out  2  per-requester response valid.
REQ-010 rsp_ready  in  2  per-requester response accept.
REQ-011 rsp_data  out  8  result, shared by both requesters.
REQ-012 rsp_err  out  1  timeout flag qualifying rsp_data.
REQ-013 alu_op1, alu_op2, alu_opcode  out  4/4/3  operands and opcode driven to the shared ALU.
REQ-014 alu_start  out  1  single-cycle ALU launch pulse.
REQ-015 alu_done  in  1  ALU result-valid strobe.
REQ-016 alu_result  in  8  ALU result.

Function
REQ-017 The block SHALL use a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE:
- req_ready[g] SHALL be 1 only for the granted index g, and only while req_valid[g]=1.
- On a handshake the block SHALL latch that requester's op1/op2/opcode, record g as owner, and go to ISSUE.
REQ-019 Arbitration SHALL be round-robin.
- Only one valid: that requester wins.
- Both valid: the requester not granted last wins.
- last_grant SHALL update only on a handshake.
REQ-020 ISSUE:
- alu_start SHALL be 1 for exactly one cycle, with alu_* driven from the latched values.
- Next state: WAIT, with the timeout counter cleared to 0.
REQ-021 alu_op1/alu_op2/alu_opcode SHALL hold the latched values from ISSUE through RESP.
REQ-022 WAIT:
- On alu_done=1: latch alu_result into rsp_data, set rsp_err=0, go to RESP.
- Otherwise the counter SHALL increment by 1.
- When the counter equals ALU_TIMEOUT: rsp_data=0, rsp_err=1, go to RESP.
REQ-023 If alu_done and the timeout occur in the same cycle, alu_done SHALL win.
REQ-024 alu_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-025 RESP:
- rsp_valid[owner] SHALL be 1 and the other rsp_valid bit 0.
- rsp_data and rsp_err SHALL stay stable until rsp_ready[owner]=1, then go to IDLE.
REQ-026 req_ready SHALL be 0 in every state other than IDLE; there is exactly one request outstanding.
REQ-027 Minimum latency, handshake to rsp_valid, SHALL be 3 cycles (ALU returning alu_done in its first WAIT cycle).
REQ-028 The counter SHALL be wide enough to hold ALU_TIMEOUT without wrap.

Reset
REQ-029 On rst assertion, the block SHALL take the reset state immediately, independent of clk:
- state = IDLE, last_grant = 1 (requester 0 wins first).
- counter and all latches = 0.
- rsp_valid, rsp_err, alu_start = 0; req_ready follows REQ-018.
REQ-030 Reset mid-operation (ISSUE, WAIT or RESP) SHALL drop the outstanding request with no response, and SHALL ignore any later alu_done.

Structure
REQ-031 Package alu_pkg SHALL hold:
- OP_W=4, OPC_W=3, RES_W=8;
- the FSM state enum;
- ALU_TIMEOUT_DEFAULT=15.
REQ-032 Round-robin grant logic SHALL be one sub-module, rr_arb2 (inputs: req[1:0], last_grant, update; output: grant).

Verification
REQ-033 Single request: req_valid=01, op1=4'h3, op2=4'h5, opcode=3'b000, alu_done one cycle after alu_start with alu_result=8'h08 -> alu_start pulses once, rsp_valid=01, rsp_data=8'h08, rsp_err=0.
REQ-034 Contention: req_valid=11 held for three transactions from reset -> grant order 0,1,0; rsp_valid bits match the owner each time.
REQ-035 Timeout: alu_done never asserted -> exactly 15 WAIT cycles, then rsp_err=1, rsp_data=0.
REQ-036 Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and alu_* held stable; req_ready=00 throughout.
REQ-037 Boundary: alu_done asserted in the cycle the counter reaches 15 -> rsp_err=0; a stray alu_done in IDLE -> no effect.
REQ-038 Reset asserted in WAIT -> next response appears only for a new request, and the first grant goes to requester 0.
